trigger_decoder: RTL and testbench

TRIGGER_DECODER -- requirements
Module: trigger_decoder

---
 rtl/trigger_decoder.sv | 152 +++++++++++++++
 tb/tb_trigger_decoder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_decoder.sv
// trigger_decoder: missing-tooth crank wheel decoder. Measures tooth periods,
// finds the gap (a period more than 1.5x the previous one), and numbers the
// teeth from the first tooth after the gap. Loses sync on a misplaced gap,
// a missing gap, or a stalled wheel.
module trigger_decoder #(
  parameter int timer_length  = 24,
  parameter int TEETH_TOTAL   = 60,
  parameter int TEETH_MISSING = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    crank_in,
  output logic [7:0]              tooth_num,
  output logic                    tooth_edge,
  output logic                    synced,
  output logic                    sync_error,
  output logic [timer_length-1:0] tooth_period
);

  localparam logic [7:0]              LAST_TOOTH = 8'(TEETH_TOTAL - TEETH_MISSING - 1);
  localparam logic [timer_length-1:0] CNT_MAX    = {timer_length{1'b1}};
  localparam logic [timer_length-1:0] CNT_ONE    = {{(timer_length-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    LOST   = 2'd0,
    FIRST  = 2'd1,
    HUNT   = 2'd2,
    SYNCED = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic                    sync1_reg, sync2_reg, hist_reg;
  logic [timer_length-1:0] cnt_reg, cnt_next;
  logic [timer_length-1:0] prev_reg, prev_next;
  logic [7:0]              num_reg, num_next;
  logic                    edge_reg, edge_next;
  logic                    err_reg, err_next;
  logic                    rise, stall, gap;
  logic [timer_length:0]   gap_limit;

  // Bring crank_in into the clock domain and keep one history flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      hist_reg  <= 1'b0;
    end else begin
      sync1_reg <= crank_in;
      sync2_reg <= sync1_reg;
      hist_reg  <= sync2_reg;
    end
  end

  assign rise  = sync2_reg & ~hist_reg;
  assign stall = (cnt_reg == CNT_MAX);

  // Gap threshold is 1.5x the previous period, one bit wider so it cannot wrap.
  assign gap_limit = {1'b0, prev_reg} + {2'b00, prev_reg[timer_length-1:1]};
  assign gap       = ({1'b0, cnt_reg} > gap_limit);

  // Period counter: restart at 1 on each tooth, otherwise count and stick at full scale.
  always_comb begin
    cnt_next = cnt_reg;
    if (rise) begin
      cnt_next = CNT_ONE;
    end else if (!stall) begin
      cnt_next = cnt_reg + CNT_ONE;
    end
  end

  // Sync state machine; a tooth edge wins over a simultaneous stall timeout.
  always_comb begin
    state_next = state_reg;
    prev_next  = prev_reg;
    num_next   = num_reg;
    edge_next  = 1'b0;
    err_next   = 1'b0;
    if (rise) begin
      if (!gap) begin
        prev_next = cnt_reg;
      end
      case (state_reg)
        LOST: begin
          state_next = FIRST;
        end
        FIRST: begin
          prev_next  = cnt_reg;
          state_next = HUNT;
        end
        HUNT: begin
          if (gap) begin
            num_next   = 8'd0;
            edge_next  = 1'b1;
            state_next = SYNCED;
          end
        end
        SYNCED: begin
          if (num_reg == LAST_TOOTH) begin
            if (gap) begin
              num_next  = 8'd0;
              edge_next = 1'b1;
            end else begin
              state_next = LOST;
              err_next   = 1'b1;
            end
          end else begin
            if (gap) begin
              state_next = LOST;
              err_next   = 1'b1;
            end else begin
              num_next  = num_reg + 8'd1;
              edge_next = 1'b1;
            end
          end
        end
        default: begin
          state_next = LOST;
        end
      endcase
    end else if (stall) begin
      state_next = LOST;
      prev_next  = '0;
      err_next   = (state_reg == SYNCED);
    end
  end

  // State, period history and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= LOST;
      cnt_reg   <= '0;
      prev_reg  <= '0;
      num_reg   <= 8'd0;
      edge_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      prev_reg  <= prev_next;
      num_reg   <= num_next;
      edge_reg  <= edge_next;
      err_reg   <= err_next;
    end
  end

  assign tooth_num    = num_reg;
  assign tooth_edge   = edge_reg;
  assign sync_error   = err_reg;
  assign synced       = (state_reg == SYNCED);
  assign tooth_period = prev_reg;

endmodule

// File: tb/tb_trigger_decoder.sv
// tb_trigger_decoder: drives two decoders (24-bit and 8-bit period timers)
// with crank waveforms; a tooth-level reference model queues the expected
// tooth_edge / sync_error events and a monitor pops and compares them.
module tb_trigger_decoder;

  localparam int LAST = 57;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       crank_a = 1'b0;
  logic       crank_b = 1'b0;
  logic [7:0] a_num, b_num;
  logic       a_edge, b_edge, a_syn, b_syn, a_err, b_err;
  logic [23:0] a_per;
  logic [7:0]  b_per;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit is_err;
    int num;
    int period;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  // Reference model state per decoder: lock flag, edges seen while unlocked,
  // reference period, expected tooth index, cycle of the last rising edge.
  int m_max[2];
  bit m_locked[2];
  int m_seen[2];
  int m_ref[2];
  int m_idx[2];
  int m_last[2];

  trigger_decoder u_dut_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .crank_in    (crank_a),
    .tooth_num   (a_num),
    .tooth_edge  (a_edge),
    .synced      (a_syn),
    .sync_error  (a_err),
    .tooth_period(a_per)
  );

  trigger_decoder #(.timer_length(8)) u_dut_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .crank_in    (crank_b),
    .tooth_num   (b_num),
    .tooth_edge  (b_edge),
    .synced      (b_syn),
    .sync_error  (b_err),
    .tooth_period(b_per)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(int d, bit is_err, int num, int period);
    ev_t e;
    e.is_err = is_err;
    e.num    = num;
    e.period = period;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic model_reset(int d);
    m_locked[d] = 1'b0;
    m_seen[d]   = 0;
    m_ref[d]    = 0;
    m_idx[d]    = 0;
    m_last[d]   = cyc;
  endtask

  task automatic model_stall(int d);
    if (m_locked[d]) push_ev(d, 1'b1, m_idx[d], 0);
    m_locked[d] = 1'b0;
    m_seen[d]   = 0;
    m_ref[d]    = 0;
  endtask

  // One rising crank edge at the current cycle.
  task automatic model_rise(int d);
    int delta, cur;
    bit big;
    delta     = cyc - m_last[d];
    m_last[d] = cyc;
    if (delta > m_max[d]) begin
      model_stall(d);
      cur = m_max[d];
    end else begin
      cur = delta;
    end
    big = (2 * cur > 3 * m_ref[d]);
    if (m_locked[d]) begin
      if (!big) m_ref[d] = cur;
      if (m_idx[d] == LAST && big) begin
        m_idx[d] = 0;
        push_ev(d, 1'b0, 0, m_ref[d]);
      end else if (m_idx[d] < LAST && !big) begin
        m_idx[d] = m_idx[d] + 1;
        push_ev(d, 1'b0, m_idx[d], m_ref[d]);
      end else begin
        m_locked[d] = 1'b0;
        m_seen[d]   = 0;
        push_ev(d, 1'b1, m_idx[d], m_ref[d]);
      end
    end else if (m_seen[d] == 0) begin
      if (!big) m_ref[d] = cur;
      m_seen[d] = 1;
    end else if (m_seen[d] == 1) begin
      m_ref[d]  = cur;
      m_seen[d] = 2;
    end else if (big) begin
      m_locked[d] = 1'b1;
      m_idx[d]    = 0;
      push_ev(d, 1'b0, 0, m_ref[d]);
    end else begin
      m_ref[d] = cur;
    end
  endtask

  // Rising edge now, next rising edge p cycles later.
  task automatic tooth(int d, int p);
    int h;
    h = p / 3;
    if (h < 1) h = 1;
    if (d == 0) crank_a = 1'b1;
    else        crank_b = 1'b1;
    model_rise(d);
    repeat (h) @(negedge clk);
    if (d == 0) crank_a = 1'b0;
    else        crank_b = 1'b0;
    repeat (p - h) @(negedge clk);
  endtask

  task automatic rev(int d, int t);
    for (int i = 0; i < LAST; i++) tooth(d, t);
    tooth(d, 3 * t);
  endtask

  task automatic rand_rev(int d, int t);
    int p, a;
    for (int i = 0; i <= LAST; i++) begin
      p = t - 2 + int'($urandom_range(0, 4));
      if (i == LAST) p = 3 * t;
      if (i < LAST && $urandom_range(0, 29) == 0) begin
        a = int'($urandom_range(20, p - 20));
        tooth(d, a);
        tooth(d, p - a);
      end else begin
        tooth(d, p);
      end
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("dut0 reset tooth_num", int'(a_num), 0);
    check("dut0 reset tooth_edge", int'(a_edge), 0);
    check("dut0 reset synced", int'(a_syn), 0);
    check("dut0 reset sync_error", int'(a_err), 0);
    check("dut0 reset tooth_period", int'(a_per), 0);
    check("dut1 reset synced", int'(b_syn), 0);
    check("dut1 reset tooth_period", int'(b_per), 0);
    check("dut0 events pending at reset", q0.size(), 0);
    check("dut1 events pending at reset", q1.size(), 0);
    q0.delete();
    q1.delete();
    model_reset(0);
    model_reset(1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic start(int d, int t);
    reset_pulse();
    repeat (3) tooth(d, t);
    tooth(d, 3 * t);
  endtask

  task automatic stall_wait(int d);
    model_stall(d);
    repeat (m_max[d] + 40) @(negedge clk);
  endtask

  task automatic mon(int d, int e, int er, int num, int per, int syn);
    ev_t x;
    int  avail;
    if (e == 0 && er == 0) return;
    avail = (d == 0) ? q0.size() : q1.size();
    if (avail == 0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d unexpected output: tooth_edge=%0d sync_error=%0d tooth_num=%0d, expected no output",
               d, e, er, num);
      return;
    end
    x = (d == 0) ? q0.pop_front() : q1.pop_front();
    check($sformatf("dut%0d both pulses", d), e & er, 0);
    check($sformatf("dut%0d sync_error kind", d), er, int'(x.is_err));
    if (!x.is_err) check($sformatf("dut%0d tooth_num", d), num, x.num);
    check($sformatf("dut%0d tooth_period", d), per, x.period);
    check($sformatf("dut%0d synced", d), syn, x.is_err ? 0 : 1);
  endtask

  // Monitor: compares every presented pulse against the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      mon(0, int'(a_edge), int'(a_err), int'(a_num), int'(a_per), int'(a_syn));
      mon(1, int'(b_edge), int'(b_err), int'(b_num), int'(b_per), int'(b_syn));
    end
  end

  initial begin
    int t;
    m_max[0] = (1 << 24) - 1;
    m_max[1] = 255;
    model_reset(0);
    model_reset(1);

    // Full revolution at 100 cycles, then a noise edge near tooth 20.
    start(0, 100);
    rev(0, 100);
    tooth(0, 100);
    for (int i = 1; i < 20; i++) tooth(0, 100);
    tooth(0, 30);
    tooth(0, 70);
    tooth(0, 100);

    // Gap arriving at tooth 30.
    start(0, 100);
    for (int i = 0; i < 30; i++) tooth(0, 100);
    tooth(0, 300);
    tooth(0, 100);

    // Expected gap after tooth 57 replaced by a normal tooth.
    start(0, 100);
    for (int i = 0; i < 59; i++) tooth(0, 100);

    // Gap threshold boundary with reference period 100.
    reset_pulse();
    repeat (3) tooth(0, 100);
    tooth(0, 150);
    repeat (3) tooth(0, 100);
    reset_pulse();
    repeat (3) tooth(0, 100);
    tooth(0, 151);
    repeat (2) tooth(0, 100);

    // Reset in the middle of a revolution, then resync.
    start(0, 100);
    for (int i = 0; i < 40; i++) tooth(0, 100);
    tooth(0, 50);
    reset_pulse();
    tooth(0, 100);
    tooth(0, 300);
    repeat (3) tooth(0, 100);

    // Randomized revolutions with period jitter and occasional split teeth.
    t = int'($urandom_range(60, 120));
    start(0, t);
    rand_rev(0, t);
    rand_rev(0, t);
    tooth(0, t);

    // 8-bit timer: gap lands exactly on saturation, then a stall.
    repeat (3) tooth(1, 85);
    tooth(1, 255);
    rev(1, 85);
    repeat (5) tooth(1, 85);
    stall_wait(1);
    check("dut1 synced after stall", int'(b_syn), 0);
    check("dut1 tooth_period after stall", int'(b_per), 0);

    repeat (20) @(negedge clk);
    check("dut0 expected events never seen", q0.size(), 0);
    check("dut1 expected events never seen", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
